// File: rtl/gon_drain_writer.sv
// -----------------------------------------------------------------------------
// gon_drain_writer
//
// Drains gathered PE words from the GON collection FIFO and writes them to
// consecutive global-buffer addresses. One burst is run per accepted `start`.
// A 2-entry skid buffer absorbs global-buffer back-pressure. The upstream
// FIFO has a one-cycle read latency, so the skid buffer is sized to hold that
// in-flight word as well.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low; clears all state
//   start       in   one-cycle burst request, honoured only in IDLE
//   base_addr   in   first write address, sampled on an accepted start
//   num_words   in   burst length, sampled on an accepted start
//   fifo_data   in   upstream FIFO read data, valid the cycle after data_rd_en
//   data_empty  in   upstream FIFO empty
//   data_rd_en  out  upstream FIFO pop (combinational from glb_ready)
//   glb_wr_en   out  write valid toward the global buffer
//   glb_addr    out  write address (base + written, wraps)
//   glb_data    out  write data (skid buffer head)
//   glb_ready   in   global buffer accepts the write this cycle
//   busy        out  high while a burst is running
//   done        out  one-cycle pulse at burst end
// -----------------------------------------------------------------------------
module gon_drain_writer #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_words,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   data_empty,
  output logic                   data_rd_en,
  output logic                   glb_wr_en,
  output logic [ADDR_WIDTH-1:0]  glb_addr,
  output logic [DATA_WIDTH-1:0]  glb_data,
  input  logic                   glb_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // FSM and burst bookkeeping
  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [COUNT_WIDTH-1:0] r_num;
  logic [COUNT_WIDTH-1:0] r_issued;
  logic [COUNT_WIDTH-1:0] r_written;

  // Read-latency tracking and skid buffer
  logic                   r_inflight;
  logic [DATA_WIDTH-1:0]  r_skid [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_skid_cnt;

  // Combinational handshake terms
  logic                   w_run;
  logic                   w_wr_en;
  logic                   w_pop;
  logic [2:0]             w_occ_next;
  logic                   w_rd_en;
  logic                   w_last_pop;

  // Handshake decode: the read request looks at next-cycle skid occupancy so
  // that a word popped this cycle frees a slot for a read issued this cycle.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_wr_en    = w_run & (r_skid_cnt != 2'd0);
    w_pop      = w_wr_en & glb_ready;
    // Pop only happens with skid_cnt >= 1, so this never underflows.
    w_occ_next = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rd_en    = w_run & ~data_empty & (r_issued < r_num) & (w_occ_next < 3'd2);
    w_last_pop = w_pop & ((r_written + CNT_ONE) == r_num);
  end

  // Burst FSM with latched parameters, counters and registered busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_base    <= {ADDR_WIDTH{1'b0}};
      r_num     <= CNT_ZERO;
      r_issued  <= CNT_ZERO;
      r_written <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base    <= base_addr;
            r_num     <= num_words;
            r_issued  <= CNT_ZERO;
            r_written <= CNT_ZERO;
            if (num_words == CNT_ZERO) begin
              // Zero-length burst: report completion without touching the FIFO.
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_rd_en) begin
            r_issued <= r_issued + CNT_ONE;
          end else begin
            r_issued <= r_issued;
          end
          if (w_pop) begin
            r_written <= r_written + CNT_ONE;
          end else begin
            r_written <= r_written;
          end
          if (w_last_pop) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Upstream read latency: the word requested last cycle arrives this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Skid buffer storage and pointers; an in-flight word always has a free slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skid[0]  <= {DATA_WIDTH{1'b0}};
      r_skid[1]  <= {DATA_WIDTH{1'b0}};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_skid[r_wr_ptr] <= fifo_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({r_inflight, w_pop})
        2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
        default: r_skid_cnt <= r_skid_cnt;
      endcase
    end
  end

  // Outputs decode directly from registers; while stalled none of the
  // contributing registers move, so address and data hold steady.
  assign data_rd_en = w_rd_en;
  assign glb_wr_en  = w_wr_en;
  assign glb_addr   = r_base + ADDR_WIDTH'(r_written);
  assign glb_data   = r_skid[r_rd_ptr];
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: doc/gon_drain_writer.md
# gon_drain_writer

Drains gathered PE words out of the GON collection FIFO (`data_out` / `data_empty` / `data_rd_en` side) and writes them to consecutive global-buffer addresses. Sits directly downstream of the GON gather FIFO. Runs one programmed burst per `start`, absorbs global-buffer back-pressure with a 2-entry skid buffer, and pulses `done` when the last word has been accepted.

## Interface
- `DATA_WIDTH`, 64, word width; equals the GON data width.
- `ADDR_WIDTH`, 12, global-buffer address width.
- `COUNT_WIDTH`, 16, burst-length counter width.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1  one-cycle burst request; honoured only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first write address; sampled on an accepted `start`.
- `num_words`  in  COUNT_WIDTH  burst length; sampled on an accepted `start`.
- `fifo_data`  in  DATA_WIDTH  upstream FIFO read data; valid the cycle after `data_rd_en`.
- `data_empty`  in  1  upstream FIFO empty.
- `data_rd_en`  out  1  upstream FIFO pop.
- `glb_wr_en`  out  1  write valid toward the global buffer.
- `glb_addr`  out  ADDR_WIDTH  write address.
- `glb_data`  out  DATA_WIDTH  write data.
- `glb_ready`  in  1  global buffer accepts the write this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at burst end.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`. Latch `base_addr` and `num_words`; clear the `issued` and `written` counters.
  - `start` with `num_words`==0: go IDLE -> DONE directly. No FIFO reads occur.
  - RUN -> DONE when an accepted write makes `written`==`num_words`.
  - DONE -> IDLE unconditionally.
- `start` in RUN or DONE is ignored. Latched parameters do not change mid-burst.
- Accepted write: `pop` = `glb_wr_en` & `glb_ready`.
- `inflight` is a register equal to the previous cycle's `data_rd_en`.
- `data_rd_en` = RUN & ~`data_empty` & (`issued` < `num_words`) & (`skid_cnt` + `inflight` - `pop` < 2).
  - The path from `glb_ready` to `data_rd_en` is combinational.
  - `data_rd_en` is never high while `data_empty`=1 or outside RUN.
- Skid buffer: 2-entry FIFO.
  - Written with `fifo_data` when `inflight`=1.
  - Read on `pop`.
  - Simultaneous write and read keeps occupancy unchanged.
  - It cannot overflow, by construction of the `data_rd_en` condition.
- `glb_wr_en` = RUN & (`skid_cnt` != 0). `glb_data` = skid head.
- `glb_addr` = `base` + `written`, truncated to ADDR_WIDTH. Wraps modulo 2^ADDR_WIDTH, e.g. 0xFFF + 1 -> 0x000.
- `issued` increments on `data_rd_en`. `written` increments on `pop`. Both are COUNT_WIDTH wide; no overflow is possible since both are bounded by `num_words`.
- `glb_wr_en`, `glb_addr` and `glb_data` hold stable while `glb_wr_en`=1 and `glb_ready`=0.
- Reset asserted mid-burst: state -> IDLE, counters and skid cleared, all outputs 0. An FIFO read already in flight is discarded. Upstream re-synchronisation is the system's responsibility.

## Timing
- Reset values: `data_rd_en`=0, `glb_wr_en`=0, `glb_addr`=0, `glb_data`=0, `busy`=0, `done`=0.
- `start` at cycle 0 -> `busy`=1 from cycle 1. The first `data_rd_en` can occur at cycle 1.
- `data_rd_en` at cycle n -> skid written at n+1 -> earliest `glb_wr_en` at n+2 (2-cycle latency).
- Throughput: 1 word/cycle while `data_empty`=0 and `glb_ready`=1.
- Last `pop` at cycle m -> `done`=1 and `busy`=0 at cycle m+1 -> IDLE at m+2. A new `start` is accepted at m+2.
- Zero-length burst: `start` at cycle 0 -> `done` at cycle 1.

## Test plan
- **Basic burst.** `base_addr`=0x010, `num_words`=4, FIFO preloaded with A,B,C,D, `glb_ready`=1 -> writes A@0x010, B@0x011, C@0x012, D@0x013 on 4 consecutive cycles starting 3 cycles after `start`; `done` pulses once, the cycle after D.
- **Back-pressure.** `num_words`=6, `glb_ready` toggles 1,0,0,1,... -> `glb_wr_en`/`glb_addr`/`glb_data` stable while stalled; never more than 2 reads outstanding; 6 in-order writes; exactly 6 `data_rd_en` pulses.
- **Starved FIFO.** `data_empty` high for 5 cycles mid-burst -> no `data_rd_en` while empty; burst resumes and completes with correct addresses.
- **Wrap and zero length.** `base_addr`=0xFFE, `num_words`=3 -> addresses 0xFFE, 0xFFF, 0x000. Then `num_words`=0 -> `done` one cycle after `start`, no reads, no writes.
- **Reset and ignored start.** `start` pulses during RUN are ignored (same count and addresses). Drop `reset` to 0 mid-burst -> all outputs 0 immediately; a subsequent `start` with new parameters runs cleanly from its new `base_addr`.
